// File: rtl/dcache_2way_wb.sv
`default_nettype none
// ============================================================================
// Module   : dcache_2way_wb
// Purpose  : 2-way set-associative, write-back, write-allocate L1 data cache
//            with a per-set LRU bit and hit/miss statistics counters. It sits
//            between the CPU MEM stage (p1_*) and a line-wide data memory
//            (mem_*). Tag, valid, dirty, LRU and data arrays are internal
//            registers.
// Ports    : clk_i, rst_i (async, active-low)
//            p1_addr_i/p1_data_i/p1_MemRead_i/p1_MemWrite_i : CPU request
//            p1_data_o  : read data, valid in the hit cycle (0 otherwise)
//            p1_stall_o : request present and not hitting (combinational)
//            mem_addr_o/mem_data_o/mem_enable_o/mem_write_o : memory request
//            mem_data_i/mem_ack_i : refill data and one-cycle completion
//            hit_cnt_o/miss_cnt_o : wrapping 32-bit statistics
// Revision : 1.0 - initial release
// ============================================================================
module dcache_2way_wb #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int INDEX_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int SETS   = 1 << INDEX_W;
    localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
    localparam int WORDS  = LINE_W / 32;
    localparam int WSEL_W = $clog2(WORDS);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_MISS        = 3'd1,
        S_WRITEBACK   = 3'd2,
        S_REFILL      = 3'd3,
        S_REFILL_DONE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]       tag_q  [2][SETS];
    logic [LINE_W-1:0]      data_q [2][SETS];
    logic [1:0][SETS-1:0]   valid_q;
    logic [1:0][SETS-1:0]   dirty_q;
    logic [SETS-1:0]        lru_q;          // way to evict next in each set

    state_t                 state_q;
    logic                   victim_q;
    logic                   refill_done_q;  // previous cycle was REFILL_DONE
    logic                   mem_enable_q;
    logic                   mem_write_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [31:0]            hit_cnt_q;
    logic [31:0]            miss_cnt_q;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_index;
    logic [WSEL_W-1:0]  w_word;
    logic [WSEL_W+4:0]  w_bitpos;
    logic               w_unused;

    assign w_tag    = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_index  = p1_addr_i[OFF_W +: INDEX_W];
    assign w_word   = p1_addr_i[2 +: WSEL_W];
    assign w_bitpos = {w_word, 5'b00000};
    assign w_unused = &{1'b0, p1_addr_i[1:0]};

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic [1:0] w_hit_way;

    for (genvar gw = 0; gw < 2; gw++) begin : g_way
        assign w_hit_way[gw] = valid_q[gw][w_index] && (tag_q[gw][w_index] == w_tag);
    end

    logic              w_req;
    logic              w_hit;
    logic              w_hit_sel;
    logic              w_rd_hit;
    logic              w_wr_hit;
    logic [LINE_W-1:0] w_hit_line;

    assign w_req      = p1_MemRead_i | p1_MemWrite_i;
    // Only one way can match, so way 1's match bit doubles as the way index.
    assign w_hit_sel  = w_hit_way[1];
    assign w_hit      = (state_q == S_IDLE) && (|w_hit_way);
    assign w_rd_hit   = w_hit & p1_MemRead_i & ~p1_MemWrite_i;
    assign w_wr_hit   = w_hit & p1_MemWrite_i;
    assign w_hit_line = data_q[w_hit_sel][w_index];

    assign p1_data_o  = w_rd_hit ? w_hit_line[w_bitpos +: 32] : 32'd0;
    assign p1_stall_o = w_req & ~w_hit;

    // ------------------------------------------------------------------
    // Victim choice: fill an empty way first, otherwise evict the LRU way
    // ------------------------------------------------------------------
    logic w_victim;
    logic w_victim_dirty;

    always_comb begin
        w_victim = lru_q[w_index];
        if (!valid_q[0][w_index]) begin
            w_victim = 1'b0;
        end else if (!valid_q[1][w_index]) begin
            w_victim = 1'b1;
        end
    end

    assign w_victim_dirty = valid_q[w_victim][w_index] & dirty_q[w_victim][w_index];

    // ------------------------------------------------------------------
    // Control FSM, metadata and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= S_IDLE;
            victim_q      <= 1'b0;
            refill_done_q <= 1'b0;
            valid_q       <= '0;
            dirty_q       <= '0;
            lru_q         <= '0;
            mem_enable_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            hit_cnt_q     <= 32'd0;
            miss_cnt_q    <= 32'd0;
        end else begin
            refill_done_q <= (state_q == S_REFILL_DONE);
            case (state_q)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            lru_q[w_index] <= ~w_hit_sel;
                            if (p1_MemWrite_i) begin
                                dirty_q[w_hit_sel][w_index] <= 1'b1;
                            end
                            // The completing hit after a refill was already
                            // counted as a miss.
                            if (!refill_done_q) begin
                                hit_cnt_q <= hit_cnt_q + 32'd1;
                            end
                        end else begin
                            miss_cnt_q <= miss_cnt_q + 32'd1;
                            state_q    <= S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    victim_q     <= w_victim;
                    mem_enable_q <= 1'b1;
                    if (w_victim_dirty) begin
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= {tag_q[w_victim][w_index], w_index, {OFF_W{1'b0}}};
                        state_q     <= S_WRITEBACK;
                    end else begin
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= {w_tag, w_index, {OFF_W{1'b0}}};
                        state_q     <= S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= {w_tag, w_index, {OFF_W{1'b0}}};
                        state_q     <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        mem_enable_q                <= 1'b0;
                        valid_q[victim_q][w_index]  <= 1'b1;
                        dirty_q[victim_q][w_index]  <= 1'b0;
                        state_q                     <= S_REFILL_DONE;
                    end
                end
                S_REFILL_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tag and data arrays (contents are don't-care until valid is set)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_wr_hit) begin
            data_q[w_hit_sel][w_index][w_bitpos +: 32] <= p1_data_i;
        end
        if ((state_q == S_REFILL) && mem_ack_i) begin
            data_q[victim_q][w_index] <= mem_data_i;
            tag_q[victim_q][w_index]  <= w_tag;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = data_q[victim_q][w_index];
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_2way_wb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dcache_2way_wb
// Purpose  : Self-checking bench for dcache_2way_wb. A reference model keeps
//            the CPU-visible memory image plus, per set, the resident lines
//            in recency order; it predicts every CPU completion and every
//            memory transaction, which a separate monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_2way_wb;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 256;
    localparam int INDEX_W = 5;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [31:0]       p1_data_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [31:0]       hit_cnt_o;
    logic [31:0]       miss_cnt_o;

    dcache_2way_wb #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .INDEX_W(INDEX_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_MemRead_i (p1_MemRead_i),
        .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fix_dly = -1;   // -1: random memory latency 0..3

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] wr_map  [int unsigned];   // CPU writes not lost by reset
    logic [31:0] mem_map [int unsigned];   // backing memory image
    int unsigned set_q   [32][$];          // resident line addresses, MRU first
    bit          dirty_map [int unsigned];
    int          m_hits, m_miss;

    typedef struct {bit is_wr; logic [31:0] addr; logic [31:0] data; bit hit; int issue;} exp_t;
    typedef struct {bit wr; logic [31:0] addr; logic [255:0] line;} mexp_t;
    exp_t  exp_q[$];
    mexp_t mexp_q[$];

    function automatic logic [31:0] init_word(int unsigned w);
        return w * 32'h9E3779B1 + 32'h0BADF00D;
    endfunction

    function automatic logic [31:0] mem_word(int unsigned w);
        if (mem_map.exists(w)) return mem_map[w];
        return init_word(w);
    endfunction

    function automatic logic [31:0] arch_word(int unsigned w);
        if (wr_map.exists(w)) return wr_map[w];
        return mem_word(w);
    endfunction

    function automatic logic [255:0] arch_line(int unsigned la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = arch_word(la / 4 + i);
        return l;
    endfunction

    function automatic void model_reset();
        wr_map.delete();
        dirty_map.delete();
        for (int s = 0; s < 32; s++) set_q[s].delete();
        m_hits = 0;
        m_miss = 0;
        exp_q.delete();
        mexp_q.delete();
    endfunction

    function automatic void model_issue(bit is_wr, logic [31:0] addr, logic [31:0] data);
        int unsigned la;
        int          s;
        int          pos;
        int unsigned v;
        exp_t        e;
        mexp_t       m;
        la  = addr & ~32'h1F;
        s   = int'((addr >> 5) & 32'h1F);
        pos = -1;
        for (int i = 0; i < set_q[s].size(); i++) if (set_q[s][i] == la) pos = i;
        e.hit = (pos >= 0);
        if (e.hit) begin
            m_hits++;
            set_q[s].delete(pos);
        end else begin
            m_miss++;
            if (set_q[s].size() == 2) begin
                v = set_q[s][1];
                if (dirty_map[v]) begin
                    m.wr = 1'b1; m.addr = v; m.line = arch_line(v);
                    mexp_q.push_back(m);
                end
                dirty_map.delete(v);
                void'(set_q[s].pop_back());
            end
            m.wr = 1'b0; m.addr = la; m.line = '0;
            mexp_q.push_back(m);
            dirty_map[la] = 1'b0;
        end
        set_q[s].push_front(la);
        e.is_wr = is_wr;
        e.addr  = addr;
        e.data  = is_wr ? 32'h0 : arch_word(addr >> 2);
        e.issue = cyc;
        exp_q.push_back(e);
        if (is_wr) begin
            wr_map[addr >> 2] = data;
            dirty_map[la]     = 1'b1;
        end
    endfunction

    // ------------------------------------------------------------------
    // Monitor: CPU completions and memory transactions
    // ------------------------------------------------------------------
    always @(negedge clk_i) begin : mon
        exp_t  e;
        mexp_t m;
        if (rst_i) begin
            if (p1_MemRead_i || p1_MemWrite_i) begin
                if (!p1_stall_o) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_completion: addr %0h with no expected access", p1_addr_i);
                    end else begin
                        e = exp_q.pop_front();
                        chk("access_addr", p1_addr_i, e.addr);
                        chk("read_data", p1_data_o, e.data);
                        chk("hit_no_stall", (cyc == e.issue), e.hit);
                    end
                end
            end else begin
                chk("idle_data_zero", p1_data_o, 32'h0);
                chk("idle_no_stall", p1_stall_o, 1'b0);
            end
            if (mem_ack_i && mem_enable_o) begin
                if (mexp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_txn: addr %0h write %0d", mem_addr_o, mem_write_o);
                end else begin
                    m = mexp_q.pop_front();
                    chk("mem_write", mem_write_o, m.wr);
                    chk("mem_addr", mem_addr_o, m.addr);
                    if (m.wr) chk("wb_line", mem_data_o, m.line);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory responder
    // ------------------------------------------------------------------
    initial begin : mem_resp
        bit           wr;
        bit           ab;
        logic [31:0]  a;
        logic [255:0] d;
        logic [255:0] l;
        int           dly;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
            if (rst_i && mem_enable_o) begin
                wr  = mem_write_o;
                a   = mem_addr_o;
                d   = mem_data_o;
                ab  = 1'b0;
                dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
                for (int k = 0; k < dly; k++) begin
                    @(posedge clk_i); #1;
                    if (!rst_i) begin
                        ab = 1'b1;
                        break;
                    end
                    chk("mem_enable_held", mem_enable_o, 1'b1);
                    chk("mem_write_held", mem_write_o, wr);
                    chk("mem_addr_held", mem_addr_o, a);
                    chk("stall_held", p1_stall_o, 1'b1);
                end
                if (!ab) begin
                    if (wr) begin
                        for (int i = 0; i < 8; i++) mem_map[a / 4 + i] = d[i*32 +: 32];
                    end else begin
                        for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_word(a / 4 + i);
                        mem_data_i = l;
                    end
                    mem_ack_i = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic access(input bit wr, input bit both, input logic [31:0] addr, input logic [31:0] data);
        bit done = 1'b0;
        model_issue(wr, addr, data);
        p1_addr_i     = addr;
        p1_data_i     = data;
        p1_MemWrite_i = wr;
        p1_MemRead_i  = !wr || both;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (!p1_stall_o) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL access_timeout: addr %0h still stalled, required completion", addr);
        end
        @(posedge clk_i); #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    task automatic cnt_chk();
        chk("hit_cnt", hit_cnt_o, m_hits);
        chk("miss_cnt", miss_cnt_o, m_miss);
    endtask

    initial begin : stim
        logic [31:0] a;
        bit          wr;
        bit          got;
        p1_addr_i     = '0;
        p1_data_i     = '0;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_mem_enable", mem_enable_o, 1'b0);
        chk("rst_mem_write", mem_write_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_hit_cnt", hit_cnt_o, 32'h0);
        chk("rst_miss_cnt", miss_cnt_o, 32'h0);
        chk("rst_stall", p1_stall_o, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // First read misses and refills 0x40
        access(1'b0, 1'b0, 32'h0000_0040, 32'h0);
        chk("t1_miss_cnt", miss_cnt_o, 32'd1);
        chk("t1_hit_cnt", hit_cnt_o, 32'd0);

        // Write hit, then read back
        access(1'b1, 1'b0, 32'h0000_0044, 32'hDEAD_BEEF);
        access(1'b0, 1'b0, 32'h0000_0044, 32'h0);
        chk("t2_hit_cnt", hit_cnt_o, 32'd2);

        // Same set (index 2): fill second way, touch it, evict dirty 0x40, reload 0x40
        access(1'b0, 1'b0, 32'h0000_0440, 32'h0);
        access(1'b0, 1'b0, 32'h0000_0444, 32'h0);
        access(1'b0, 1'b0, 32'h0000_0840, 32'h0);
        access(1'b0, 1'b0, 32'h0000_0040, 32'h0);
        access(1'b0, 1'b0, 32'h0000_0044, 32'h0);
        cnt_chk();

        // Slow memory
        fix_dly = 10;
        access(1'b0, 1'b0, 32'h0000_1048, 32'h0);
        access(1'b1, 1'b0, 32'h0000_1440, 32'h1234_5678);
        fix_dly = -1;
        cnt_chk();

        // Randomised traffic over 4 tags x 4 sets x 8 words
        for (int i = 0; i < 400; i++) begin
            a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            wr = 1'($urandom_range(0, 1));
            access(wr, wr && ($urandom_range(0, 3) == 0), a, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #1;
            if (i % 50 == 49) cnt_chk();
        end
        cnt_chk();

        // Reset while a refill is outstanding
        fix_dly = 20;
        model_issue(1'b0, 32'h0000_1C40, 32'h0);
        p1_addr_i    = 32'h0000_1C40;
        p1_MemRead_i = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk_i); #1;
            if (mem_enable_o && !mem_write_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL refill_wait_timeout: mem_enable_o %0d, required refill request", mem_enable_o);
        end
        #2;
        rst_i = 1'b0;
        #1;
        chk("midrst_mem_enable", mem_enable_o, 1'b0);
        chk("midrst_mem_write", mem_write_o, 1'b0);
        chk("midrst_miss_cnt", miss_cnt_o, 32'h0);
        chk("midrst_hit_cnt", hit_cnt_o, 32'h0);
        p1_MemRead_i = 1'b0;
        model_reset();
        fix_dly = -1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        access(1'b0, 1'b0, 32'h0000_0040, 32'h0);
        chk("t6_miss_cnt", miss_cnt_o, 32'd1);
        chk("t6_hit_cnt", hit_cnt_o, 32'd0);

        repeat (3) @(posedge clk_i);
        #1;
        chk("pending_accesses", exp_q.size(), 0);
        chk("pending_mem_txns", mexp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        checks++; errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
